lsu_mem: RTL
============

// Module: lsu_mem
// PURPOSE
//  Multicycle load/store unit fronting the DPI-C memory model (npc_mem_read / npc_mem_write).
//  Accepts one request per valid/ready handshake and waits a programmable LATENCY.
//  Performs exactly one DPI access, then returns the byte/half/word result, sign/zero-extended.
//  Sits between EXU and WBU of the multicycle core.
// PARAMETERS
//  LATENCY  1            cycles spent in BUSY before the DPI access; legal 1..15
//  ADDR_LO  32'h8000_0000 lowest legal byte address (inclusive)
//  ADDR_HI  32'h87FF_FFFF highest legal byte address (inclusive)
// PORTS
//  clk        in   1   clock; all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   unit can accept; =1 only in IDLE
//  req_wen    in   1   1=store, 0=load
//  req_op     in   3   funct3: load 0 LB,1 LH,2 LW,4 LBU,5 LHU; store 0 SB,1 SH,2 SW
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-aligned (byte/half in low bits)
//  rsp_valid  out  1   response present; held until rsp_ready
//  rsp_ready  in   1   consumer accepts response
//  rsp_rdata  out  32  extended load result; 0 for stores
//  rsp_err    out  1   access fault (see CONFIGURATION); 0 when macro off
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, captured request cleared.
//  FSM IDLE -> BUSY on req_valid&&req_ready: latch wen/op/addr/wdata; cnt<=LATENCY-1.
//  BUSY: cnt!=0 -> cnt--. At cnt==0, on that edge: perform DPI access, latch result, -> RESP.
//  RESP: rsp_valid=1; rsp_* stable until rsp_valid&&rsp_ready, then -> IDLE.
//  Latency: accept at edge E0 -> rsp_valid high from edge E0+LATENCY. No request overlap.
//  Minimum spacing between accepts is LATENCY+2 cycles (RESP and IDLE each take >=1).
//  req_* ignored outside IDLE.
//  DPI addr: {addr[31:2],2'b00}; one call per request; none in IDLE/RESP.
//  DPI store: npc_mem_write(addr_al, wdata<<(8*addr[1:0]), {4'b0,mask}).
//  Store mask: SB 4'b0001<<off; SH 4'b0011<<off truncated to 4 bits (off 3 -> 4'b1000); SW 4'b1111.
//  Load lane: byte=word[8*off+:8].
//  Load half: off0 [15:0], off1 [23:8], off2 [31:16], off3 -> 16'h0.
//  Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW whole word.
//  Illegal op (3,6,7; store op>=3): no DPI call, rdata=0.
//  Out-of-range addr (<ADDR_LO or >ADDR_HI): no DPI call, rdata=0, same latency.
//  Reset mid-op: pending request dropped. If reset precedes the BUSY cnt==0 edge, no write occurs.
//  Reset in the same cycle as req_valid: request not accepted.
// CONFIGURATION
//  LSU_MISALIGN_CHK_EN defined:
//   - misaligned LH/LHU/SH (addr[0]) or LW/SW (addr[1:0]!=0) -> no DPI call, rdata=0, rsp_err=1.
//   - illegal op and out-of-range also set rsp_err=1.
//  Undefined: rsp_err tied 0; misaligned accesses follow lane rules above.
// STRUCTURE
//  lsu_pkg: typedef enum {LSU_IDLE,LSU_BUSY,LSU_RESP} lsu_state_e;
//   op localparams (OP_B/H/W/BU/HU); functions wmask_gen(op,off), store_shift(wdata,off).
//  Sub-module lsu_align (combinational): word + op + off -> extended rdata; ties the load lane mux.
//  FSM, counter and DPI calls stay in lsu_mem.
// TESTING
//  LATENCY=3. At 0x8000_0000 word 0x8899_AABB: LB 0x8000_0001 -> rsp_valid at E0+3, rdata 0xFFFF_FFAA.
//  LHU 0x8000_0002 -> 0x0000_8899. LW 0x8000_0000 -> 0x8899_AABB.
//  SH 0x8000_0002 wdata 0x1234 -> one npc_mem_write, mask 4'b1100, data 0x1234_0000.
//   Subsequent LW -> 0x1234_AABB.
//  rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0. Release -> IDLE next cycle.
//  LW 0x9000_0000 -> rdata 0, zero DPI calls. rsp_err=1 with macro, 0 without.
//  Reset 1 cycle after SW accept (LATENCY=3) -> no write, rsp_valid stays 0, req_ready=1 after reset.
//  Macro on, LW 0x8000_0002 -> rsp_err=1, rdata 0, no DPI. Macro off -> rdata = aligned word.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state type, funct3 op encodings and store helpers for lsu_mem.
// Also holds the SystemVerilog stand-in for the npc_mem_read / npc_mem_write
// memory model, so the unit can be simulated without a C-side library.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] OP_B  = 3'd0;
    localparam logic [2:0] OP_H  = 3'd1;
    localparam logic [2:0] OP_W  = 3'd2;
    localparam logic [2:0] OP_BU = 3'd4;
    localparam logic [2:0] OP_HU = 3'd5;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MEM_AW    = 10;
    localparam int unsigned MEM_WORDS = 1 << MEM_AW;

    // Byte-enable for a store; the halfword shift drops lanes past byte 3.
    function automatic logic [3:0] wmask_gen(input logic [2:0] op, input logic [1:0] off);
        logic [3:0] mask;
        mask = 4'b0000;
        case (op)
            OP_B:    mask = 4'b0001 << off;
            OP_H:    mask = 4'b0011 << off;
            OP_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Move right-aligned store data onto its byte lanes.
    function automatic logic [31:0] store_shift(input logic [31:0] wdata, input logic [1:0] off);
        return wdata << {off, 3'b000};
    endfunction

    // Memory model state: word array (aliased on low address bits) plus call tracking.
    logic [31:0] npc_mem_words [MEM_WORDS];
    int unsigned npc_rd_calls;
    int unsigned npc_wr_calls;
    logic [31:0] npc_last_waddr;
    logic [31:0] npc_last_wdata;
    logic [7:0]  npc_last_wmask;

    // Word read at an aligned byte address.
    function automatic logic [31:0] npc_mem_read(input logic [31:0] raddr);
        npc_rd_calls = npc_rd_calls + 1;
        return npc_mem_words[MEM_AW'(raddr >> 2)];
    endfunction

    // Byte-masked word write at an aligned byte address.
    function automatic void npc_mem_write(input logic [31:0] waddr, input logic [31:0] wdata,
                                          input logic [7:0] wmask);
        logic [31:0] word;
        logic [3:0]  lanes;
        lanes = 4'(wmask);
        word  = npc_mem_words[MEM_AW'(waddr >> 2)];
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) word[8*i +: 8] = wdata[8*i +: 8];
        end
        npc_mem_words[MEM_AW'(waddr >> 2)] = word;
        npc_wr_calls   = npc_wr_calls + 1;
        npc_last_waddr = waddr;
        npc_last_wdata = wdata;
        npc_last_wmask = wmask;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: picks the addressed byte/halfword out of an aligned word and extends it.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    output logic [31:0] rdata_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select; a halfword starting at byte 3 has no upper byte and reads as zero.
    always_comb begin
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        case (off)
            2'd0: begin byte_lane = word[7:0];   half_lane = word[15:0];  end
            2'd1: begin byte_lane = word[15:8];  half_lane = word[23:8];  end
            2'd2: begin byte_lane = word[23:16]; half_lane = word[31:16]; end
            default: begin byte_lane = word[31:24]; half_lane = 16'h0000; end
        endcase
    end

    // Sign/zero extension by load opcode; unknown ops return zero.
    always_comb begin
        rdata_c = 32'h0000_0000;
        case (op)
            OP_B:    rdata_c = {{24{byte_lane[7]}}, byte_lane};
            OP_H:    rdata_c = {{16{half_lane[15]}}, half_lane};
            OP_W:    rdata_c = word;
            OP_BU:   rdata_c = {24'h000000, byte_lane};
            OP_HU:   rdata_c = {16'h0000, half_lane};
            default: rdata_c = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// lsu_mem: multicycle load/store unit between EXU and WBU. One request at a time,
// LATENCY cycles in BUSY, a single memory-model access, then a held response.
// Optional: define LSU_MISALIGN_CHK_EN to fault misaligned, illegal-op and
// out-of-range accesses through rsp_err; otherwise rsp_err is always 0.
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter logic [31:0] ADDR_LO = 32'h8000_0000,
    parameter logic [31:0] ADDR_HI = 32'h87FF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    lsu_state_e       state;
    lsu_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic             wen_q;
    logic [2:0]       op_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      word_q;

    logic             accept_c;
    logic             fire_c;
    logic             op_legal_c;
    logic             in_range_c;
    logic             do_access_c;
    logic             fault_c;
    logic [31:0]      addr_al_c;
    logic [31:0]      rdata_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LSU_IDLE;
        else     state <= state_next;
    end

    // Next state plus accept/fire strobes.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        fire_c     = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (req_valid) begin
                    accept_c   = 1'b1;
                    state_next = LSU_BUSY;
                end
            end
            LSU_BUSY: begin
                if (cnt == '0) begin
                    fire_c     = 1'b1;
                    state_next = LSU_RESP;
                end
            end
            LSU_RESP: begin
                if (rsp_ready) state_next = LSU_IDLE;
            end
            default: state_next = LSU_IDLE;
        endcase
    end

    // Decide whether the captured request may touch memory.
    always_comb begin
        addr_al_c  = {addr_q[31:2], 2'b00};
        op_legal_c = wen_q ? (op_q inside {OP_B, OP_H, OP_W})
                           : (op_q inside {OP_B, OP_H, OP_W, OP_BU, OP_HU});
        in_range_c = (addr_q >= ADDR_LO) && (addr_q <= ADDR_HI);
`ifdef LSU_MISALIGN_CHK_EN
        do_access_c = op_legal_c && in_range_c &&
                      !((op_q[1:0] == 2'd1 && addr_q[0]) ||
                        (op_q[1:0] == 2'd2 && addr_q[1:0] != 2'd0));
        fault_c     = !do_access_c;
`else
        do_access_c = op_legal_c && in_range_c;
        fault_c     = 1'b0;
`endif
    end

    // Request capture, latency counter, the single memory access and response flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            wen_q     <= 1'b0;
            op_q      <= 3'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            word_q    <= 32'h0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            req_ready <= (state_next == LSU_IDLE);
            rsp_valid <= (state_next == LSU_RESP);
            if (accept_c) begin
                wen_q   <= req_wen;
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                word_q  <= 32'h0;
                rsp_err <= 1'b0;
                cnt     <= CNT_W'(LATENCY - 1);
            end else if (state == LSU_BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (fire_c) begin
                rsp_err <= fault_c;
                if (do_access_c && wen_q) begin
                    npc_mem_write(addr_al_c, store_shift(wdata_q, addr_q[1:0]),
                                  {4'b0000, wmask_gen(op_q, addr_q[1:0])});
                end else if (do_access_c) begin
                    word_q <= npc_mem_read(addr_al_c);
                end
            end
        end
    end

    // Stores and suppressed accesses leave word_q at zero, so they return zero.
    lsu_align u_align (
        .word    (word_q),
        .op      (op_q),
        .off     (addr_q[1:0]),
        .rdata_c (rdata_c)
    );

    assign rsp_rdata = rdata_c;

endmodule
